uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (legal 5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, number of s_tick periods in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 SHALL have port rx, input, 1 bit: asynchronous serial line, idle high, LSB first.
REQ-006 SHALL have port s_tick, input, 1 bit: one-clk enable pulse at 16x the baud rate.
REQ-007 SHALL have port dout, output, DBIT bits: last received data word.
REQ-008 SHALL have port rx_done_tick, output, 1 bit: one-clk pulse when a frame completes.
REQ-009 SHALL have port frame_err, output, 1 bit: stop bit of the last completed frame sampled low.

Function
REQ-010 SHALL pass rx through a 2-flop synchronizer; both flops reset to 1; the FSM uses only the second flop (rx_s).
REQ-011 SHALL implement FSM states idle, start, data and stop, with a 4-bit tick counter s, a 3-bit bit counter n and a DBIT-bit shift register b.
REQ-012 idle: when rx_s==0, SHALL go to start and clear s; s_tick is not required for this transition.
REQ-013 start, on s_tick with s==7 (mid start bit), SHALL do one of two things:
  - rx_s==0: go to data with s=0, n=0.
  - rx_s==1: false start; return to idle with no pulse, dout and frame_err unchanged.
REQ-014 start, on s_tick with s!=7: SHALL increment s.
REQ-015 data, on s_tick with s==15: SHALL shift b right, set b[DBIT-1]=rx_s and clear s.
  - If n==DBIT-1: go to stop.
  - Otherwise: increment n.
REQ-016 data, on s_tick with s!=15: SHALL increment s.
REQ-017 stop, on s_tick with s==SB_TICK-1 (s widened as needed for SB_TICK up to 32): SHALL go to idle and, on the next edge, load dout=b, load frame_err=~rx_s and pulse rx_done_tick high for exactly one clk.
REQ-018 stop, on s_tick with s!=SB_TICK-1: SHALL increment s.
REQ-019 All counters SHALL advance only on cycles where s_tick=1; with s_tick held low, state, s, n and b SHALL hold.
REQ-020 First data bit received SHALL end at dout[0] (LSB first).
REQ-021 dout and frame_err SHALL be registered and hold their values until the next completed frame; a false start or reset-aborted frame SHALL NOT alter them.
REQ-022 rx_done_tick SHALL never be asserted on two consecutive clk cycles.
REQ-023 A low on rx_s in the same cycle as the return to idle SHALL be accepted as the next start bit on the following cycle (back-to-back frames, no gap required beyond the stop bit).
REQ-024 No overrun detection: the consumer SHALL capture dout on rx_done_tick; a new frame overwrites dout.

Reset
REQ-025 When reset=1 at a clk edge, the block SHALL set: state=idle, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, both synchronizer flops=1.
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_done_tick.
REQ-027 After reset, the block SHALL require rx_s==0 again, through a new start-bit detection, before receiving.

Verification
REQ-028 Bench SHALL cover the following scenarios (DBIT=8, SB_TICK=16, s_tick every 4 clk):
  - Frame 0xA5 with valid stop -> dout=0xA5, frame_err=0, exactly one rx_done_tick, ~16*10 ticks after the start edge.
  - rx low for 3 ticks then high (glitch) -> no rx_done_tick; FSM back in idle; dout unchanged.
  - Frame 0x3C with stop bit forced low -> dout=0x3C, frame_err=1, one rx_done_tick; next good frame 0x5A -> frame_err=0.
  - Back-to-back frames 0x00 then 0xFF, no idle gap -> two pulses, dout=0x00 then 0xFF.
  - Reset asserted during data bit 4 of frame 0x81 -> all outputs 0, no pulse; following frame 0x42 received as 0x42.
  - s_tick held low for 50 clk mid data bit -> frame still decodes correctly (0x99), with reception delayed by 50 clk.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, mid-bit sampling, LSB first, configurable data and stop length.
// Reports each completed frame with a one-cycle done pulse plus a stop-bit framing error flag.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e          state_q, state_d;
  logic [4:0]      s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q;
  logic            frame_err_q;
  logic            done_q, done_d;
  logic            rx_meta_q, rx_s_q;

  // Idle line is high, so the synchronizer resets to 1 to avoid a phantom start bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      s_q         <= '0;
      n_q         <= '0;
      b_q         <= '0;
      dout_q      <= '0;
      frame_err_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      done_q  <= done_d;
      if (done_d) begin
        dout_q      <= b_q;
        frame_err_q <= ~rx_s_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == 5'd7) begin
            // Still low at mid start bit: real start; otherwise a glitch.
            if (!rx_s_q) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == 5'd15) begin
            s_d = '0;
            b_d = {rx_s_q, b_q[DBIT-1:1]};
            if (n_q == 3'(DBIT - 1)) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 5'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout         = dout_q;
  assign frame_err    = frame_err_q;
  assign rx_done_tick = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: drives serial frames at 16 ticks per bit with s_tick every 4 clk,
// and checks received words, framing errors and pulse timing against the transmitted frames.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       s_tick = 1'b0;
  logic [7:0] dout;
  logic       rx_done_tick;
  logic       frame_err;

  int         n_cmp = 0;
  int         n_err = 0;
  bit         tick_en = 1'b1;
  int         div = 0;
  longint     cyc = 0;
  longint     t_start = 0;
  bit         prev_done = 1'b0;
  bit         consec = 1'b0;

  // Pulses seen on rx_done_tick, with the outputs captured alongside.
  logic [7:0] obs_d[$];
  bit         obs_fe[$];
  longint     obs_cyc[$];

  // Start edge to done pulse: 8 ticks of start + 8 data bits + 16 stop ticks, 4 clk per tick.
  localparam longint Nominal = 4 * (8 + 16 * 8 + 16);

  uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx           (rx),
    .s_tick       (s_tick),
    .dout         (dout),
    .rx_done_tick (rx_done_tick),
    .frame_err    (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tick_en) begin
      div    = (div == 3) ? 0 : div + 1;
      s_tick = (div == 3);
    end else begin
      s_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_done_tick) begin
      obs_d.push_back(dout);
      obs_fe.push_back(frame_err);
      obs_cyc.push_back(cyc);
      if (prev_done) consec = 1'b1;
    end
    prev_done = rx_done_tick;
  end

  task automatic clear_obs();
    obs_d.delete();
    obs_fe.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      do begin
        @(posedge clk);
        guard++;
      end while (!s_tick && guard < 200);
      if (guard >= 200) begin
        n_cmp++;
        n_err++;
        $display("FAIL tick_timeout: got no s_tick in %0d clk, required one", guard);
      end
    end
    @(negedge clk);
  endtask

  // abort_bit/stall_bit < 0 disable those behaviours; an abort returns mid-bit with rx low or high.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int abort_bit,
                            input int stall_bit);
    t_start = cyc;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == abort_bit) begin
        wait_ticks(8);
        return;
      end
      if (i == stall_bit) begin
        wait_ticks(8);
        tick_en = 1'b0;
        repeat (50) @(negedge clk);
        tick_en = 1'b1;
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    if (stop_ok) begin
      rx = 1'b1;
      wait_ticks(16);
    end else begin
      // Short low stop so the line is high again before the false-start check.
      rx = 1'b0;
      wait_ticks(10);
      rx = 1'b1;
      wait_ticks(16);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL reset_dout: got %h required 00", dout); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_ferr: got %b required 0", frame_err); end
    n_cmp++; if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", rx_done_tick); end
    reset = 1'b0;
    clear_obs();
    wait_ticks(40);
    n_cmp++; if (obs_d.size() != 0) begin n_err++; $display("FAIL idle_no_pulse: got %0d pulses required 0", obs_d.size()); end
  endtask

  task automatic test_frame();
    longint lat;
    clear_obs();
    send_frame(8'hA5, 1'b1, -1, -1);
    wait_ticks(4);
    n_cmp++; if (obs_d.size() != 1) begin n_err++; $display("FAIL a5_pulses: got %0d required 1", obs_d.size()); end
    if (obs_d.size() >= 1) begin
      lat = obs_cyc[0] - t_start;
      n_cmp++; if (obs_d[0] !== 8'hA5) begin n_err++; $display("FAIL a5_dout: got %h required a5", obs_d[0]); end
      n_cmp++; if (obs_fe[0] !== 1'b0) begin n_err++; $display("FAIL a5_ferr: got %b required 0", obs_fe[0]); end
      n_cmp++; if (lat < Nominal - 8 || lat > Nominal + 8) begin
        n_err++; $display("FAIL a5_latency: got %0d clk required %0d +/- 8", lat, Nominal);
      end
    end
    n_cmp++; if (dout !== 8'hA5) begin n_err++; $display("FAIL a5_hold: got %h required a5", dout); end
  endtask

  task automatic test_glitch();
    logic [7:0] d0;
    logic       fe0;
    d0 = dout;
    fe0 = frame_err;
    clear_obs();
    rx = 1'b0;
    wait_ticks(3);
    rx = 1'b1;
    wait_ticks(30);
    n_cmp++; if (obs_d.size() != 0) begin n_err++; $display("FAIL glitch_pulse: got %0d required 0", obs_d.size()); end
    n_cmp++; if (dout !== d0) begin n_err++; $display("FAIL glitch_dout: got %h required %h", dout, d0); end
    n_cmp++; if (frame_err !== fe0) begin n_err++; $display("FAIL glitch_ferr: got %b required %b", frame_err, fe0); end
  endtask

  task automatic test_frame_err();
    clear_obs();
    send_frame(8'h3C, 1'b0, -1, -1);
    send_frame(8'h5A, 1'b1, -1, -1);
    wait_ticks(4);
    n_cmp++; if (obs_d.size() != 2) begin n_err++; $display("FAIL ferr_pulses: got %0d required 2", obs_d.size()); end
    if (obs_d.size() >= 2) begin
      n_cmp++; if (obs_d[0] !== 8'h3C) begin n_err++; $display("FAIL ferr_dout: got %h required 3c", obs_d[0]); end
      n_cmp++; if (obs_fe[0] !== 1'b1) begin n_err++; $display("FAIL ferr_flag: got %b required 1", obs_fe[0]); end
      n_cmp++; if (obs_d[1] !== 8'h5A) begin n_err++; $display("FAIL ferr_next_dout: got %h required 5a", obs_d[1]); end
      n_cmp++; if (obs_fe[1] !== 1'b0) begin n_err++; $display("FAIL ferr_next_flag: got %b required 0", obs_fe[1]); end
    end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    wait_ticks(4);
    n_cmp++; if (obs_d.size() != 2) begin n_err++; $display("FAIL b2b_pulses: got %0d required 2", obs_d.size()); end
    if (obs_d.size() >= 2) begin
      n_cmp++; if (obs_d[0] !== 8'h00) begin n_err++; $display("FAIL b2b_first: got %h required 00", obs_d[0]); end
      n_cmp++; if (obs_d[1] !== 8'hFF) begin n_err++; $display("FAIL b2b_second: got %h required ff", obs_d[1]); end
    end
  endtask

  task automatic test_abort();
    clear_obs();
    send_frame(8'h81, 1'b1, 4, -1);
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (dout !== 8'h00) begin n_err++; $display("FAIL abort_dout: got %h required 00", dout); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL abort_ferr: got %b required 0", frame_err); end
    n_cmp++; if (rx_done_tick !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b required 0", rx_done_tick); end
    reset = 1'b0;
    rx = 1'b1;
    wait_ticks(200);
    n_cmp++; if (obs_d.size() != 0) begin n_err++; $display("FAIL abort_pulse: got %0d required 0", obs_d.size()); end
    clear_obs();
    send_frame(8'h42, 1'b1, -1, -1);
    wait_ticks(4);
    n_cmp++; if (obs_d.size() != 1) begin n_err++; $display("FAIL after_abort_pulses: got %0d required 1", obs_d.size()); end
    if (obs_d.size() >= 1) begin
      n_cmp++; if (obs_d[0] !== 8'h42) begin n_err++; $display("FAIL after_abort_dout: got %h required 42", obs_d[0]); end
    end
  endtask

  task automatic test_stall();
    longint lat;
    clear_obs();
    send_frame(8'h99, 1'b1, -1, 3);
    wait_ticks(4);
    n_cmp++; if (obs_d.size() != 1) begin n_err++; $display("FAIL stall_pulses: got %0d required 1", obs_d.size()); end
    if (obs_d.size() >= 1) begin
      lat = obs_cyc[0] - t_start;
      n_cmp++; if (obs_d[0] !== 8'h99) begin n_err++; $display("FAIL stall_dout: got %h required 99", obs_d[0]); end
      n_cmp++; if (lat < Nominal + 50 - 8 || lat > Nominal + 50 + 8) begin
        n_err++; $display("FAIL stall_latency: got %0d clk required %0d +/- 8", lat, Nominal + 50);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 10; k++) begin
      logic [7:0] d;
      bit         ok;
      d  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 3) != 0);
      clear_obs();
      send_frame(d, ok, -1, -1);
      wait_ticks($urandom_range(2, 10));
      n_cmp++; if (obs_d.size() != 1) begin n_err++; $display("FAIL rand%0d_pulses: got %0d required 1", k, obs_d.size()); end
      if (obs_d.size() >= 1) begin
        n_cmp++; if (obs_d[0] !== d) begin n_err++; $display("FAIL rand%0d_dout: got %h required %h", k, obs_d[0], d); end
        n_cmp++; if (obs_fe[0] !== !ok) begin n_err++; $display("FAIL rand%0d_ferr: got %b required %b", k, obs_fe[0], !ok); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_abort();
    test_stall();
    test_random();
    n_cmp++; if (consec !== 1'b0) begin n_err++; $display("FAIL done_consecutive: got %b required 0", consec); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
